masku_operand_buffer: RTL and testbench

- Sits directly upstream of the mask-unit operand unpacking stage.
- Accepts per-lane, per-operand ELEN words from the lanes through independent valid/ready handshakes.
- Buffers each word in a small FIFO and releases a lane-aligned operand bundle only when every lane holds the operands the current instruction needs.
- This decouples lane skew from masku execution.

---
 rtl/masku_operand_buffer_pkg.sv | 18 +
 rtl/masku_operand_buffer_op_fifo.sv | 79 +++++++
 rtl/masku_operand_buffer.sv | 84 ++++++++
 tb/tb_masku_operand_buffer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/masku_operand_buffer_pkg.sv
// ============================================================================
// Module   : ara_pkg
// Brief    : Shared element width, mask-unit sizing and operand buffer defaults.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ara_pkg;

    localparam int unsigned ELEN            = 64;
    localparam int unsigned NrMaskFUnits    = 2;
    localparam int unsigned MaskuOpBufDepth = 2;

    typedef logic [ELEN-1:0] elen_t;

endpackage : ara_pkg

`default_nettype wire

// File: rtl/masku_operand_buffer_op_fifo.sv
// ============================================================================
// Module   : masku_op_fifo
// Brief    : One-word-wide FIFO with occupancy count, explicit pointer wrap
//            and synchronous flush; no fall-through from input to head.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module masku_op_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_nonempty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_push;
    logic             w_pop;
    logic [PTR_W-1:0] w_wr_ptr_nxt;
    logic [PTR_W-1:0] w_rd_ptr_nxt;

    // Ready depends only on the registered count, never on a same-cycle pop.
    assign o_ready    = (r_count < CNT_W'(DEPTH));
    assign o_nonempty = (r_count != '0);
    assign o_data     = r_mem[r_rd_ptr];

    assign w_push = i_valid & o_ready;
    assign w_pop  = i_pop & o_nonempty;

    // Explicit wrap so DEPTH need not be a power of two.
    assign w_wr_ptr_nxt = (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
    assign w_rd_ptr_nxt = (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= w_wr_ptr_nxt;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : masku_op_fifo

`default_nettype wire

// File: rtl/masku_operand_buffer.sv
// ============================================================================
// Module   : masku_operand_buffer
// Brief    : Per-lane/per-operand skew buffer releasing lane-aligned operand
//            bundles to the mask unit once every needed word is present.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module masku_operand_buffer
    import ara_pkg::*;
#(
    parameter int unsigned NrLanes = 4,
    parameter int unsigned NrOps   = NrMaskFUnits + 2,
    parameter int unsigned Depth   = MaskuOpBufDepth
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                flush_i,
    input  logic [NrOps-1:0]                    op_needed_i,
    input  elen_t [NrLanes-1:0][NrOps-1:0]      masku_operand_i,
    input  logic  [NrLanes-1:0][NrOps-1:0]      masku_operand_valid_i,
    output logic  [NrLanes-1:0][NrOps-1:0]      masku_operand_ready_o,
    output elen_t [NrLanes-1:0][NrOps-1:0]      masku_operands_o,
    output logic                                masku_operands_valid_o,
    input  logic                                masku_operands_ready_i,
    output logic [15:0]                         bundles_popped_o
);

    logic  [NrLanes-1:0][NrOps-1:0] w_nonempty;
    elen_t [NrLanes-1:0][NrOps-1:0] w_head;
    logic                           w_valid;
    logic                           w_pop;
    logic [15:0]                    r_popped;

    for (genvar l = 0; l < int'(NrLanes); l++) begin : g_lane
        for (genvar o = 0; o < int'(NrOps); o++) begin : g_op
            masku_op_fifo #(
                .WIDTH (ELEN),
                .DEPTH (Depth)
            ) u_fifo (
                .clk_i      (clk_i),
                .rst_ni     (rst_ni),
                .flush_i    (flush_i),
                .i_valid    (masku_operand_valid_i[l][o]),
                .o_ready    (masku_operand_ready_o[l][o]),
                .i_data     (masku_operand_i[l][o]),
                .i_pop      (w_pop & op_needed_i[o]),
                .o_data     (w_head[l][o]),
                .o_nonempty (w_nonempty[l][o])
            );

            assign masku_operands_o[l][o] = op_needed_i[o] ? w_head[l][o] : '0;
        end
    end

    // An instruction needing no operands never produces a bundle.
    always_comb begin
        w_valid = |op_needed_i;
        for (int l = 0; l < int'(NrLanes); l++) begin
            for (int o = 0; o < int'(NrOps); o++) begin
                if (op_needed_i[o] && !w_nonempty[l][o]) begin
                    w_valid = 1'b0;
                end
            end
        end
    end

    assign w_pop                  = w_valid & masku_operands_ready_i;
    assign masku_operands_valid_o = w_valid;
    assign bundles_popped_o       = r_popped;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_popped <= '0;
        end else if (flush_i) begin
            r_popped <= '0;
        end else if (w_pop && (r_popped != 16'hFFFF)) begin
            r_popped <= r_popped + 16'd1;
        end
    end

endmodule : masku_operand_buffer

`default_nettype wire

// File: tb/tb_masku_operand_buffer.sv
// ============================================================================
// Module   : tb_masku_operand_buffer
// Brief    : Directed self-checking bench for masku_operand_buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_masku_operand_buffer;
    import ara_pkg::*;

    localparam int NL = 4;
    localparam int NO = NrMaskFUnits + 2;

    typedef elen_t [NL-1:0][NO-1:0] bundle_t;

    logic                   clk_i = 1'b0;
    logic                   rst_ni;
    logic                   flush_i;
    logic [NO-1:0]          op_needed;
    bundle_t                op_in;
    logic [NL-1:0][NO-1:0]  v_in;
    logic [NL-1:0][NO-1:0]  r_out;
    bundle_t                op_out;
    logic                   valid_o;
    logic                   ready_i;
    logic [15:0]            popped;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    masku_operand_buffer #(
        .NrLanes (NL),
        .NrOps   (NO),
        .Depth   (MaskuOpBufDepth)
    ) dut (
        .clk_i                  (clk_i),
        .rst_ni                 (rst_ni),
        .flush_i                (flush_i),
        .op_needed_i            (op_needed),
        .masku_operand_i        (op_in),
        .masku_operand_valid_i  (v_in),
        .masku_operand_ready_o  (r_out),
        .masku_operands_o       (op_out),
        .masku_operands_valid_o (valid_o),
        .masku_operands_ready_i (ready_i),
        .bundles_popped_o       (popped)
    );

    function automatic elen_t word(input int l, input int o, input int n);
        return elen_t'(64'hC0DE_0000_0000_0000) | elen_t'(l * 4096 + o * 256 + n);
    endfunction

    function automatic bundle_t exp_bundle(input logic [NO-1:0] need, input int n);
        bundle_t b;
        for (int l = 0; l < NL; l++)
            for (int o = 0; o < NO; o++)
                b[l][o] = need[o] ? word(l, o, n) : '0;
        return b;
    endfunction

    task automatic step;
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [NL-1:0] lanes, input int n);
        for (int l = 0; l < NL; l++)
            for (int o = 0; o < NO; o++) begin
                v_in[l][o]  = lanes[l] & op_needed[o];
                op_in[l][o] = word(l, o, n);
            end
    endtask

    task automatic do_flush;
        v_in    = '0;
        flush_i = 1'b1;
        step;
        flush_i = 1'b0;
    endtask

    task automatic test_reset;
        op_needed = '1;
        #12;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b want=0", valid_o); end
        checks++; if (op_out !== '0) begin errors++; $display("FAIL rst_data got=%0h want=0", op_out); end
        checks++; if (popped !== 16'd0) begin errors++; $display("FAIL rst_popped got=%0d want=0", popped); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        step;
        checks++; if (r_out !== '1) begin errors++; $display("FAIL rst_ready got=%0h want=all-ones", r_out); end
    endtask

    task automatic test_basic;
        op_needed = 4'b0111;
        ready_i   = 1'b0;
        drive(4'b1111, 1);
        op_in[0][1] = 64'hA5;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL basic_prevalid got=%b want=0", valid_o); end
        step;
        v_in = '0;
        checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b want=1", valid_o); end
        checks++; if (op_out[0][1] !== 64'hA5) begin errors++; $display("FAIL basic_l0op1 got=%0h want=a5", op_out[0][1]); end
        checks++; if (op_out[2][2] !== word(2, 2, 1)) begin errors++; $display("FAIL basic_l2op2 got=%0h want=%0h", op_out[2][2], word(2, 2, 1)); end
        checks++; if ({op_out[0][3], op_out[1][3], op_out[2][3], op_out[3][3]} !== '0) begin
            errors++; $display("FAIL basic_op3_zero got=%0h want=0", {op_out[0][3], op_out[1][3], op_out[2][3], op_out[3][3]});
        end
        op_needed = '0;
        #1;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL basic_noneed got=%b want=0", valid_o); end
        op_needed = 4'b0111;
        ready_i   = 1'b1;
        step;
        ready_i = 1'b0;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL basic_after_pop got=%b want=0", valid_o); end
        checks++; if (popped !== 16'd1) begin errors++; $display("FAIL basic_popped got=%0d want=1", popped); end
    endtask

    task automatic test_skew;
        do_flush;
        op_needed = 4'b0111;
        ready_i   = 1'b0;
        for (int c = 0; c <= 5; c++) begin
            v_in = '0;
            if (c == 0) drive(4'b0111, 10);
            if (c == 5) drive(4'b1000, 10);
            checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL skew_wait c=%0d got=%b want=0", c, valid_o); end
            step;
        end
        v_in = '0;
        checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL skew_rise got=%b want=1", valid_o); end
        checks++; if (op_out !== exp_bundle(4'b0111, 10)) begin errors++; $display("FAIL skew_data got=%0h want=%0h", op_out, exp_bundle(4'b0111, 10)); end
        ready_i = 1'b1;
        step;
        ready_i = 1'b0;
        checks++; if (popped !== 16'd1) begin errors++; $display("FAIL skew_popped got=%0d want=1", popped); end
    endtask

    task automatic test_backpressure;
        do_flush;
        op_needed = 4'b0111;
        ready_i   = 1'b0;
        drive(4'b1111, 0);
        step;
        drive(4'b1111, 1);
        step;
        v_in = '0;
        v_in[1][2]  = 1'b1;
        op_in[1][2] = word(1, 2, 2);
        checks++; if (r_out[1][2] !== 1'b0) begin errors++; $display("FAIL bp_full_ready got=%b want=0", r_out[1][2]); end
        step;
        v_in    = '0;
        ready_i = 1'b1;
        checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL bp_valid0 got=%b want=1", valid_o); end
        checks++; if (op_out !== exp_bundle(4'b0111, 0)) begin errors++; $display("FAIL bp_bundle0 got=%0h want=%0h", op_out, exp_bundle(4'b0111, 0)); end
        step;
        checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL bp_valid1 got=%b want=1", valid_o); end
        checks++; if (op_out !== exp_bundle(4'b0111, 1)) begin errors++; $display("FAIL bp_bundle1 got=%0h want=%0h", op_out, exp_bundle(4'b0111, 1)); end
        checks++; if (r_out[1][2] !== 1'b1) begin errors++; $display("FAIL bp_ready_back got=%b want=1", r_out[1][2]); end
        step;
        ready_i = 1'b0;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL bp_drained got=%b want=0", valid_o); end
        checks++; if (popped !== 16'd2) begin errors++; $display("FAIL bp_popped got=%0d want=2", popped); end
        checks++; if (r_out !== '1) begin errors++; $display("FAIL bp_ready_all got=%0h want=all-ones", r_out); end
    endtask

    task automatic test_streaming;
        do_flush;
        op_needed = 4'b0111;
        ready_i   = 1'b1;
        for (int n = 0; n <= 100; n++) begin
            if (n < 100) drive(4'b1111, n);
            else v_in = '0;
            checks++; if (valid_o !== (n >= 1)) begin errors++; $display("FAIL stream_valid n=%0d got=%b want=%b", n, valid_o, (n >= 1)); end
            if (n >= 1) begin
                checks++; if (op_out !== exp_bundle(4'b0111, n - 1)) begin
                    errors++; $display("FAIL stream_data n=%0d got=%0h want=%0h", n, op_out, exp_bundle(4'b0111, n - 1));
                end
            end
            step;
        end
        ready_i = 1'b0;
        checks++; if (popped !== 16'd100) begin errors++; $display("FAIL stream_popped got=%0d want=100", popped); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL stream_end got=%b want=0", valid_o); end
    endtask

    task automatic test_flush;
        do_flush;
        op_needed = 4'b0111;
        ready_i   = 1'b0;
        drive(4'b1111, 0);
        step;
        drive(4'b1111, 1);
        step;
        v_in    = '0;
        ready_i = 1'b1;
        step;
        ready_i = 1'b0;
        drive(4'b1111, 2);
        step;
        v_in = '0;
        checks++; if (popped !== 16'd1) begin errors++; $display("FAIL flush_pre_popped got=%0d want=1", popped); end
        flush_i     = 1'b1;
        ready_i     = 1'b1;
        v_in[0][3]  = 1'b1;
        op_in[0][3] = 64'hDEAD;
        checks++; if (r_out[0][3] !== 1'b1) begin errors++; $display("FAIL flush_ready got=%b want=1", r_out[0][3]); end
        step;
        flush_i = 1'b0;
        ready_i = 1'b0;
        v_in    = '0;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b want=0", valid_o); end
        checks++; if (popped !== 16'd0) begin errors++; $display("FAIL flush_popped got=%0d want=0", popped); end
        checks++; if (r_out !== '1) begin errors++; $display("FAIL flush_counts got=%0h want=all-ones", r_out); end
        op_needed = 4'b1000;
        #1;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL flush_dropped_push got=%b want=0", valid_o); end
        op_needed = 4'b0111;
        drive(4'b1111, 7);
        step;
        v_in = '0;
        checks++; if (op_out !== exp_bundle(4'b0111, 7)) begin errors++; $display("FAIL flush_fresh got=%0h want=%0h", op_out, exp_bundle(4'b0111, 7)); end
        ready_i = 1'b1;
        step;
        ready_i = 1'b0;
    endtask

    task automatic test_async_reset;
        op_needed = 4'b0111;
        ready_i   = 1'b0;
        drive(4'b1111, 3);
        step;
        v_in = '0;
        checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL arst_pre_valid got=%b want=1", valid_o); end
        #2;
        rst_ni = 1'b0;
        #1;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL arst_valid got=%b want=0", valid_o); end
        checks++; if (op_out !== '0) begin errors++; $display("FAIL arst_data got=%0h want=0", op_out); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        step;
        checks++; if (r_out !== '1) begin errors++; $display("FAIL arst_ready got=%0h want=all-ones", r_out); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL arst_no_replay got=%b want=0", valid_o); end
        drive(4'b1111, 4);
        step;
        v_in = '0;
        checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL arst_post_valid got=%b want=1", valid_o); end
        checks++; if (op_out !== exp_bundle(4'b0111, 4)) begin errors++; $display("FAIL arst_post_data got=%0h want=%0h", op_out, exp_bundle(4'b0111, 4)); end
    endtask

    initial begin
        rst_ni    = 1'b0;
        flush_i   = 1'b0;
        op_needed = '0;
        op_in     = '0;
        v_in      = '0;
        ready_i   = 1'b0;
        test_reset;
        test_basic;
        test_skew;
        test_backpressure;
        test_streaming;
        test_flush;
        test_async_reset;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule : tb_masku_operand_buffer

`default_nettype wire
